gate_result_mux4to1: RTL and testbench

Four-to-one gathering multiplexer that merges the four per-gate result streams of the LSTM datapath back into one 32-bit stream. It is the return path for the 1-to-4 gate demultiplexer. Each word is tagged with the 2-bit lane index, using the same encoding as the demux select, so downstream logic can tell which gate produced it. Arbitration between lanes is round-robin with valid/ready handshakes on every port and a single registered output stage.

---
 rtl/gate_result_mux4to1.sv | 112 +++++++++++
 tb/tb_gate_result_mux4to1.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gate_result_mux4to1.sv
// gate_result_mux4to1
//
// Gathers the four per-gate LSTM result streams back into one stream. Each
// merged word carries a 2-bit tag naming the lane (gate) that produced it,
// using the same encoding as the gate demux select. Lanes are served
// round-robin behind a single registered output stage.
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous active-high reset
//   enable                 0 blocks new input words; the output stage still drains
//   in_data1..4            lane data (lane1 = gate 0 ... lane4 = gate 3)
//   in_valid1..4           lane word valid
//   in_ready1..4           lane word accepted this cycle when valid & ready
//   out_data               registered merged data
//   out_sel                registered source tag (00 = lane1 ... 11 = lane4)
//   out_valid              output stage holds a word
//   out_ready              downstream accepts the word when out_valid & out_ready

module gate_result_mux4to1 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    input  logic [DATA_WIDTH-1:0] in_data3,
    input  logic [DATA_WIDTH-1:0] in_data4,
    input  logic                  in_valid1,
    input  logic                  in_valid2,
    input  logic                  in_valid3,
    input  logic                  in_valid4,
    output logic                  in_ready1,
    output logic                  in_ready2,
    output logic                  in_ready3,
    output logic                  in_ready4,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [3:0]            valid_vec;
    logic [3:0]            grant;
    logic [1:0]            grant_idx;
    logic                  grant_any;
    logic [1:0]            last;
    logic                  load_ok;
    logic                  accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] grant_data;

    assign valid_vec = {in_valid4, in_valid3, in_valid2, in_valid1};

    // Round-robin search starting one lane after the last grant. The fourth
    // step wraps to 'last' itself, so a lone valid lane is always reachable.
    always_comb begin
        logic [1:0] idx;
        grant     = 4'b0000;
        grant_idx = 2'b00;
        grant_any = 1'b0;
        idx       = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!grant_any && valid_vec[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

    // The stage can take a word if it is empty or being drained this cycle.
    // rst is folded in so that no handshake completes while it is asserted.
    assign load_ok = ~out_valid | out_ready;
    assign accept  = enable & load_ok & ~rst;
    assign xfer    = accept & grant_any;

    assign in_ready1 = accept & grant[0];
    assign in_ready2 = accept & grant[1];
    assign in_ready3 = accept & grant[2];
    assign in_ready4 = accept & grant[3];

    always_comb begin
        grant_data = in_data1;
        case (grant_idx)
            2'd0:    grant_data = in_data1;
            2'd1:    grant_data = in_data2;
            2'd2:    grant_data = in_data3;
            default: grant_data = in_data4;
        endcase
    end

    // 'last' resets to lane4 so that lane1 is first in line after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'b00;
            last      <= 2'b11;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant_idx;
            last      <= grant_idx;
        end else if (load_ok) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_result_mux4to1.sv
module tb_gate_result_mux4to1;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [W-1:0] in_data1, in_data2, in_data3, in_data4;
    logic         in_valid1, in_valid2, in_valid3, in_valid4;
    logic         in_ready1, in_ready2, in_ready3, in_ready4;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    gate_result_mux4to1 #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3), .in_data4(in_data4),
        .in_valid1(in_valid1), .in_valid2(in_valid2), .in_valid3(in_valid3), .in_valid4(in_valid4),
        .in_ready1(in_ready1), .in_ready2(in_ready2), .in_ready3(in_ready3), .in_ready4(in_ready4),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         r;
        logic         en;
        logic [3:0]   v;
        logic         ordy;
        logic [W-1:0] base;   // lane K carries base + K
        logic [3:0]   rdy;    // expected {in_ready4..1} during the cycle
        logic         ov;     // expected outputs after the edge
        logic [1:0]   sel;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string name, logic r, logic en, logic [3:0] v, logic ordy,
                                logic [W-1:0] base, logic [3:0] rdy, logic ov,
                                logic [1:0] sel, logic [W-1:0] data);
        vec_t t;
        t.name = name; t.r = r; t.en = en; t.v = v; t.ordy = ordy; t.base = base;
        t.rdy = rdy; t.ov = ov; t.sel = sel; t.data = data;
        tbl.push_back(t);
    endfunction

    function automatic logic [3:0] rdy_vec();
        return {in_ready4, in_ready3, in_ready2, in_ready1};
    endfunction

    task automatic drive(logic r, logic en, logic [3:0] v, logic ordy,
                         logic [W-1:0] d0, logic [W-1:0] d1, logic [W-1:0] d2, logic [W-1:0] d3);
        rst = r; enable = en; out_ready = ordy;
        {in_valid4, in_valid3, in_valid2, in_valid1} = v;
        in_data1 = d0; in_data2 = d1; in_data3 = d2; in_data4 = d3;
    endtask

    // Reference model: output stage contents plus the lane most recently served.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_last;

    // Serve the first valid lane after the one most recently served, if the
    // stage can take a word at all.
    function automatic logic [3:0] model_ready(logic r, logic en, logic [3:0] v, logic ordy);
        logic [3:0] res = 4'b0000;
        if (r || !en || !(!m_valid || ordy)) return res;
        for (int k = 1; k <= 4; k++) begin
            int lane = (m_last + k) % 4;
            if (v[lane]) begin
                res[lane] = 1'b1;
                return res;
            end
        end
        return res;
    endfunction

    logic         pend  [4];
    logic [W-1:0] pdata [4];

    initial begin
        // reset: all lanes valid, ready stays low
        add("reset0",  1, 1, 4'b1111, 1, 32'h0, 4'b0000, 0, 2'd0, 32'h0);
        add("reset1",  1, 1, 4'b1111, 1, 32'h0, 4'b0000, 0, 2'd0, 32'h0);
        // single lane3 word
        add("single",  0, 1, 4'b0100, 1, 32'hCAFE0000, 4'b0100, 1, 2'd2, 32'hCAFE0003);
        add("idle",    0, 1, 4'b0000, 1, 32'h0, 4'b0000, 0, 2'd2, 32'hCAFE0003);
        add("rst_rr",  1, 1, 4'b0000, 1, 32'h0, 4'b0000, 0, 2'd0, 32'h0);
        // round robin over all four lanes, no gaps
        for (int c = 0; c < 8; c++)
            add("rr", 0, 1, 4'b1111, 1, 32'h0, 4'(1 << (c % 4)), 1, 2'(c % 4), 32'(c % 4 + 1));
        // backpressure holds the lane2 word, then lane3 precedes lane1
        add("bp_load", 0, 1, 4'b0010, 1, 32'h20, 4'b0010, 1, 2'd1, 32'h22);
        for (int c = 0; c < 3; c++)
            add("bp_hold", 0, 1, 4'b0101, 0, 32'h20, 4'b0000, 1, 2'd1, 32'h22);
        add("bp_l3",   0, 1, 4'b0101, 1, 32'h20, 4'b0100, 1, 2'd2, 32'h23);
        add("bp_l1",   0, 1, 4'b0001, 1, 32'h20, 4'b0001, 1, 2'd0, 32'h21);
        // enable gating: held word still drains, lane4 waits
        add("en_hold", 0, 0, 4'b1000, 0, 32'h40, 4'b0000, 1, 2'd0, 32'h21);
        add("en_drn",  0, 0, 4'b1000, 1, 32'h40, 4'b0000, 0, 2'd0, 32'h21);
        add("en_off",  0, 0, 4'b1000, 1, 32'h40, 4'b0000, 0, 2'd0, 32'h21);
        add("en_off",  0, 0, 4'b1000, 1, 32'h40, 4'b0000, 0, 2'd0, 32'h21);
        add("en_on",   0, 1, 4'b1000, 1, 32'h40, 4'b1000, 1, 2'd3, 32'h44);
        // reset mid-stream under backpressure
        add("mr_hold", 0, 1, 4'b0000, 0, 32'h50, 4'b0000, 1, 2'd3, 32'h44);
        add("mr_rst",  1, 1, 4'b0000, 0, 32'h50, 4'b0000, 0, 2'd0, 32'h0);
        add("mr_l2",   0, 1, 4'b1010, 1, 32'h50, 4'b0010, 1, 2'd1, 32'h52);

        drive(1, 0, 4'b0000, 0, '0, '0, '0, '0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].en, tbl[i].v, tbl[i].ordy,
                  tbl[i].base + 1, tbl[i].base + 2, tbl[i].base + 3, tbl[i].base + 4);
            #1;
            total++;
            if (rdy_vec() !== tbl[i].rdy) begin
                bad++;
                $display("FAIL %s[%0d] in_ready got=%b want=%b", tbl[i].name, i, rdy_vec(), tbl[i].rdy);
            end
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== tbl[i].ov ||
                (tbl[i].ov && (out_sel !== tbl[i].sel || out_data !== tbl[i].data))) begin
                bad++;
                $display("FAIL %s[%0d] out got v=%b sel=%0d data=%h want v=%b sel=%0d data=%h",
                         tbl[i].name, i, out_valid, out_sel, out_data, tbl[i].ov, tbl[i].sel, tbl[i].data);
            end
            if (tbl[i].r && (out_sel !== 2'd0 || out_data !== '0)) begin
                total++;
                bad++;
                $display("FAIL %s[%0d] reset regs got sel=%0d data=%h want sel=0 data=0",
                         tbl[i].name, i, out_sel, out_data);
            end
        end

        // Randomized traffic against the model. Each lane holds its word
        // until served; the first cycle resets both DUT and model.
        for (int k = 0; k < 4; k++) begin pend[k] = 1'b0; pdata[k] = '0; end
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = 3;
        for (int c = 0; c < 3000; c++) begin
            logic       r, en, ordy;
            logic [3:0] v, exp_rdy;
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k]  = 1'b1;
                    pdata[k] = $urandom;
                end
            v    = {pend[3], pend[2], pend[1], pend[0]};
            r    = (c == 0) || ($urandom_range(63) == 0);
            en   = $urandom_range(7) != 0;
            ordy = $urandom_range(3) != 0;
            drive(r, en, v, ordy, pdata[0], pdata[1], pdata[2], pdata[3]);
            #1;
            exp_rdy = model_ready(r, en, v, ordy);
            total++;
            if (rdy_vec() !== exp_rdy) begin
                bad++;
                $display("FAIL rand[%0d] in_ready got=%b want=%b", c, rdy_vec(), exp_rdy);
            end
            @(posedge clk);
            if (r) begin
                m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = 3;
            end else if ((exp_rdy & v) != 4'b0000) begin
                for (int k = 0; k < 4; k++)
                    if (exp_rdy[k]) begin
                        m_valid = 1'b1; m_data = pdata[k]; m_sel = k; m_last = k;
                        pend[k] = 1'b0;
                    end
            end else if (!m_valid || ordy) begin
                m_valid = 1'b0;
            end
            #1;
            total++;
            if (out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || int'(out_sel) != m_sel))) begin
                bad++;
                $display("FAIL rand[%0d] out got v=%b sel=%0d data=%h want v=%b sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
